// File: rtl/mul_unit_pkg.sv
// mul_unit_pkg: shared CPU encodings for the multiply unit
package mul_unit_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam logic [3:0] REG_PC = 4'd15;
endpackage

// File: rtl/mul_unit.sv
// mul_unit: iterative radix-2 shift-add MUL/MLA with early termination and flag write-back
module mul_unit
  import mul_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] op_acc,
  input  logic             accumulate,
  input  logic             set_flags,
  input  logic [3:0]       sel_dest,
  input  logic [3:0]       flags_in,
  output logic             busy,
  output logic             done,
  output logic             wr_enable,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       sel_out,
  output logic [3:0]       flags_out
);
  localparam int CW = $clog2(WIDTH);
  state_e state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d, result_q, result_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0] sel_q, sel_d, fin_q, fin_d, flags_q, flags_d, res_flags;
  logic sf_q, sf_d, busy_q, done_q;
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    prod_d = prod_q;
    count_d = count_q;
    sel_d = sel_q;
    sf_d = sf_q;
    fin_d = fin_q;
    if (flush) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (start) begin
          mcand_d = op_a;
          mplier_d = op_b;
          prod_d = accumulate ? op_acc : '0;
          sel_d = sel_dest;
          sf_d = set_flags;
          fin_d = flags_in;
          count_d = '0;
          state_d = (op_b == '0) ? DONE : RUN;
        end
        RUN: begin
          prod_d = mplier_q[0] ? prod_q + mcand_q : prod_q;
          mcand_d = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d = count_q + CW'(1);
          state_d = (count_q == CW'(WIDTH - 1) || (EARLY_TERM && (mplier_q >> 1) == '0)) ? DONE : RUN;
        end
        default: state_d = IDLE;
      endcase
    end
    res_flags = fin_d;
    if (sf_d) begin
      res_flags[FLAG_N] = prod_d[WIDTH-1];
      res_flags[FLAG_Z] = (prod_d == '0);
    end
    result_d = (state_d == DONE) ? prod_d : result_q;
    flags_d = (state_d == DONE) ? res_flags : flags_q;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplier_q <= '0;
      prod_q <= '0;
      count_q <= '0;
      sel_q <= '0;
      sf_q <= 1'b0;
      fin_q <= '0;
      result_q <= '0;
      flags_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      prod_q <= prod_d;
      count_q <= count_d;
      sel_q <= sel_d;
      sf_q <= sf_d;
      fin_q <= fin_d;
      result_q <= result_d;
      flags_q <= flags_d;
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == DONE);
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign wr_enable = done_q;
  assign result = result_q;
  assign sel_out = sel_q;
  assign flags_out = flags_q;
endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Iterative multiply/multiply-accumulate unit (ARM MUL/MLA) in the execute stage, directly downstream of the register file.
- Consumes the two operand read ports (plus an accumulator operand) and produces a write-back value, destination select and flags for the register file's write port.
- Radix-2 shift-add datapath with a start/busy/done handshake; multi-cycle with early termination.

Parameters:
- WIDTH, 32, operand/result width.
- EARLY_TERM, 1, 1 = stop when remaining multiplier bits are zero; 0 = always WIDTH iterations.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  request; accepted only in IDLE.
- flush  in  1  synchronous abort; returns to IDLE with no write-back.
- op_a  in  WIDTH  multiplicand (Rm).
- op_b  in  WIDTH  multiplier (Rs).
- op_acc  in  WIDTH  accumulator (Rn); used when accumulate=1.
- accumulate  in  1  1 = MLA, 0 = MUL.
- set_flags  in  1  S bit.
- sel_dest  in  4  destination register index.
- flags_in  in  4  current flags {N,Z,C,V}, bit3 = N.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse in DONE.
- wr_enable  out  1  register-file write enable; equal to done.
- result  out  WIDTH  low WIDTH bits of op_a*op_b (+op_acc).
- sel_out  out  4  latched sel_dest.
- flags_out  out  4  flags for write-back.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - State = IDLE.
  - busy, done, wr_enable = 0.
  - result = 0, sel_out = 0, flags_out = 0.
  - Internal multiplicand, multiplier and counter = 0.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - With start=1, latch the following and go to RUN (or straight to DONE if op_b==0):
    - mcand = op_a
    - mplier = op_b
    - prod = op_acc if accumulate, else 0
    - sel_out = sel_dest
    - set_flags and flags_in
    - count = 0
- RUN, each cycle:
  - If mplier[0], then prod += mcand (mod 2^WIDTH).
  - mcand <<= 1, mplier >>= 1, count += 1.
  - Go to DONE when count reaches WIDTH-1 in that cycle.
  - With EARLY_TERM=1, also go to DONE when the shifted mplier is 0.
- DONE (exactly one cycle):
  - done = 1, wr_enable = 1.
  - result = final prod.
  - Next state is IDLE.
- Latency from the accepting edge to the done pulse: bitlen(op_b)+1 cycles (EARLY_TERM=1), or WIDTH+1 cycles (EARLY_TERM=0).
  - op_b==0 gives 1 cycle (accumulator value or 0 is returned).
- Flags:
  - If the latched set_flags=1, flags_out = {result[WIDTH-1], result==0, C_in, V_in}; C and V are preserved from the latched flags_in.
  - Otherwise flags_out = latched flags_in.
  - flags_out is valid with done.
- Hold behaviour: result, sel_out and flags_out hold their values after DONE until the next accept.
- start while busy: ignored, no queuing.
- start in the DONE cycle: ignored; a new start is accepted the following IDLE cycle.
- flush:
  - Priority: reset_n > flush > start.
  - flush in RUN or DONE returns to IDLE next cycle with done = wr_enable = 0.
  - result keeps its previous value.
  - flush together with start in IDLE: start is not accepted.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values.
- Overflow: upper product bits are discarded; no error indication.
- The register file samples its write port on the rising edge, so wr_enable/result/sel_out/flags_out are stable during the whole DONE cycle.

Decomposition:
- Shared CPU package holds:
  - State encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
  - REG_PC=4'd15.
- No sub-module: the datapath (adder, shifters, counter) and the FSM live in one module.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with start=1 -> busy=0, done=0, result=0, flags_out=0; no transition out of IDLE.
- MUL 7*6:
  - Stimulus: op_a=7, op_b=6, accumulate=0, sel_dest=3, set_flags=1, flags_in=4'b0011.
  - Response: done pulses 4 cycles after accept; result=42, sel_out=3, flags_out=4'b0011, wr_enable high for exactly one cycle.
- MLA with wrap:
  - Stimulus: op_a=0xFFFFFFFF, op_b=2, op_acc=5, accumulate=1, set_flags=1.
  - Response: result=3 (0x1FFFFFFFE+5 mod 2^32), flags_out N=0, Z=0; latency 3 cycles.
- Zero multiplier:
  - Stimulus: op_b=0, accumulate=0, set_flags=1, flags_in=4'b1000.
  - Response: done 1 cycle after accept; result=0, flags_out=4'b0100.
- Negative result and full length:
  - Stimulus: op_a=1, op_b=0x80000000, set_flags=1.
  - Response: latency 33 cycles; result=0x80000000, N=1.
  - Same operands with EARLY_TERM=0 and op_b=1: latency 33 cycles.
- Busy/flush:
  - start pulsed while busy -> no effect on the running operation's result.
  - flush asserted in RUN -> IDLE next cycle, no done/wr_enable pulse.
  - A start one cycle later is accepted normally.
